// File: rtl/snn_pkg.sv
// Shared constants and readout state type for the spike-rate decoder.
package snn_pkg;

  localparam int unsigned N_CH_DEF  = 8;
  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/spike_counter_sat.sv
// One channel's saturating spike counter; count_next is the value including this cycle's spike.
module spike_counter_sat #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] cnt_q;

  assign count_next = (inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= count_next;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Per-channel windowed spike counting with a shadow bank streamed out one channel per beat.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [N_CH-1:0]         spike_in,
  input  logic                    clr_ovr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_last,
  output logic                    overrun
);

  localparam int unsigned CH_W = $clog2(N_CH);

  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic             len_pend_q;
  logic             len_load;
  logic [WIN_W-1:0] len_eff;
  logic             count_en;
  logic             win_end;

  logic [N_CH-1:0][CNT_W-1:0] cnt_next;
  logic [N_CH-1:0][CNT_W-1:0] bank_q;

  rd_state_t        state_q, state_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             overrun_q;
  logic             last_acc;
  logic             snap;

  // The freshly sampled length governs the very cycle it is latched, so each
  // window is exactly the length that was presented at its first cycle.
  always_comb begin
    len_load = en & (len_pend_q | (win_len_q == '0));
    len_eff  = len_load ? win_len : win_len_q;
    count_en = en & (len_eff != '0);
    win_end  = count_en & (win_cnt_q == len_eff - WIN_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      len_pend_q <= 1'b1;
    end else begin
      if (len_load) begin
        win_len_q <= win_len;
      end
      if (win_end) begin
        win_cnt_q <= '0;
      end else if (count_en) begin
        win_cnt_q <= win_cnt_q + WIN_W'(1);
      end
      if (win_end) begin
        len_pend_q <= 1'b1;
      end else if (len_load) begin
        len_pend_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    spike_counter_sat #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .en        (count_en),
      .inc       (spike_in[i]),
      .clr       (win_end),
      .count_next(cnt_next[i])
    );
  end

  assign out_valid = (state_q == RD_SEND);
  assign out_ch    = out_ch_q;
  assign out_count = bank_q[out_ch_q];
  assign out_last  = out_valid & (out_ch_q == CH_W'(N_CH - 1));
  assign overrun   = overrun_q;

  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    last_acc = out_valid & out_ready & out_last;
    snap     = win_end & ((state_q == RD_IDLE) | last_acc);
    unique case (state_q)
      RD_IDLE: begin
        if (snap) begin
          state_d  = RD_SEND;
          out_ch_d = '0;
        end
      end
      RD_SEND: begin
        if (out_ready) begin
          if (!out_last) begin
            out_ch_d = out_ch_q + CH_W'(1);
          end else begin
            out_ch_d = '0;
            state_d  = snap ? RD_SEND : RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RD_IDLE;
      out_ch_q  <= '0;
      bank_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_ch_q <= out_ch_d;
      if (snap) begin
        bank_q <= cnt_next;
      end
      // A new overrun takes precedence over a simultaneous clear.
      if (win_end && !snap) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with a cycle-level rate model and literal spot checks.
module tb_spike_rate_decoder;

  localparam int N    = 8;
  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       rst, en, clr_ovr, out_ready;
  logic [7:0] win_len, spike_in;
  logic       out_valid, out_last, overrun;
  logic [2:0] out_ch;
  logic [7:0] out_count;

  // Second instance with narrow counters for the saturation case.
  logic       s_en, s_ready, s_clr;
  logic [7:0] s_win_len, s_spike;
  logic       s_valid, s_last, s_ovr;
  logic [2:0] s_ch;
  logic [3:0] s_count;

  int checks = 0;
  int errors = 0;

  spike_rate_decoder #(.N_CH(8), .WIN_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .win_len  (win_len),
    .spike_in (spike_in),
    .clr_ovr  (clr_ovr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_count(out_count),
    .out_last (out_last),
    .overrun  (overrun)
  );

  spike_rate_decoder #(.N_CH(8), .WIN_W(8), .CNT_W(4)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .en       (s_en),
    .win_len  (s_win_len),
    .spike_in (s_spike),
    .clr_ovr  (s_clr),
    .out_valid(s_valid),
    .out_ready(s_ready),
    .out_ch   (s_ch),
    .out_count(s_count),
    .out_last (s_last),
    .overrun  (s_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rate model: window position, per-channel totals, a pending snapshot stream.
  int m_live[N];
  int m_bank[N];
  int m_pos, m_len, m_idx;
  bit m_need, m_busy, m_ovr;

  initial begin : model
    int len;
    bit loadable, active, ended, take;
    int fin[N];
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          m_live[i] = 0;
          m_bank[i] = 0;
        end
        m_pos = 0; m_len = 0; m_idx = 0;
        m_need = 1'b1; m_busy = 1'b0; m_ovr = 1'b0;
      end else begin
        loadable = en && (m_need || m_len == 0);
        len      = loadable ? int'(win_len) : m_len;
        active   = en && (len != 0);
        ended    = active && (m_pos == len - 1);
        for (int i = 0; i < N; i++) begin
          fin[i] = m_live[i] + int'(spike_in[i]);
          if (fin[i] > MAXC) fin[i] = MAXC;
        end
        take = ended && (!m_busy || (out_ready && m_idx == N - 1));
        if (m_busy && out_ready) begin
          if (m_idx == N - 1) begin
            m_busy = 1'b0;
            m_idx  = 0;
          end else begin
            m_idx++;
          end
        end
        if (take) begin
          m_bank = fin;
          m_busy = 1'b1;
          m_idx  = 0;
        end
        if (ended && !take) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
        if (loadable) m_len = int'(win_len);
        if (ended) m_need = 1'b1;
        else if (loadable) m_need = 1'b0;
        for (int i = 0; i < N; i++) m_live[i] = ended ? 0 : (active ? fin[i] : m_live[i]);
        m_pos = ended ? 0 : (active ? m_pos + 1 : m_pos);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m_valid", int'(out_valid), int'(m_busy));
        chk("m_overrun", int'(overrun), int'(m_ovr));
        if (m_busy) begin
          chk("m_ch", int'(out_ch), m_idx);
          chk("m_count", int'(out_count), m_bank[m_idx]);
          chk("m_last", int'(out_last), int'(m_idx == N - 1));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    en = 0; clr_ovr = 0; spike_in = '0; win_len = '0; out_ready = 0;
    s_en = 0; s_spike = '0; s_win_len = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_ready = 1'b1; s_clr = 1'b0;
    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_count", int'(out_count), 0);

    // Full-rate spiking, back-to-back streams.
    en = 1; win_len = 8'd4; spike_in = 8'hFF; out_ready = 1;
    tick(3);
    chk("t1_pre_valid", int'(out_valid), 0);
    tick(1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_ch0", int'(out_ch), 0);
    chk("t1_cnt0", int'(out_count), 4);
    win_len = 8'd8;
    tick(7);
    chk("t1_ch7", int'(out_ch), 7);
    chk("t1_last", int'(out_last), 1);
    chk("t1_cnt7", int'(out_count), 4);
    tick(1);
    chk("t1_b2b_valid", int'(out_valid), 1);
    chk("t1_b2b_ch", int'(out_ch), 0);
    chk("t1_b2b_cnt", int'(out_count), 8);
    en = 0;
    tick(8);
    chk("t1_idle", int'(out_valid), 0);
    chk("t1_ovr", int'(overrun), 0);

    // Sparse pattern; window-end spike counted, next-cycle spike deferred.
    do_reset();
    en = 1; win_len = 8'd10; out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      spike_in = '0;
      spike_in[0] = (c < 10) && (c % 2 == 0);
      spike_in[3] = (c == 9) || (c == 10);
      tick(1);
      if (c == 9) begin
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_ch0", int'(out_count), 5);
      end
      if (c == 11) chk("t2_ch2", int'(out_count), 0);
      if (c == 12) begin
        chk("t2_ch3_idx", int'(out_ch), 3);
        chk("t2_ch3", int'(out_count), 1);
      end
      if (c == 19) chk("t2_w2_ch0", int'(out_count), 0);
    end
    spike_in = '0; en = 0;
    tick(3);
    chk("t2_w2_ch3", int'(out_count), 1);
    tick(6);

    // Saturation on the 4-bit instance.
    do_reset();
    s_en = 1; s_win_len = 8'd255; s_spike = 8'hFF;
    tick(254);
    chk("t3_pre_valid", int'(s_valid), 0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_valid", int'(s_valid), 1);
      chk("t3_ch", int'(s_ch), i);
      chk("t3_cnt", int'(s_count), 15);
      chk("t3_last", int'(s_last), int'(i == 7));
      s_en = 0;
      tick(1);
    end
    chk("t3_done", int'(s_valid), 0);
    chk("t3_ovr", int'(s_ovr), 0);

    // Stalled readout, overrun, set-over-clear, then clear.
    do_reset();
    en = 1; win_len = 8'd3; out_ready = 0; spike_in = 8'h05;
    tick(3);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_cnt0", int'(out_count), 3);
    chk("t4_ovr0", int'(overrun), 0);
    spike_in = 8'hFF;
    tick(3);
    chk("t4_ovr1", int'(overrun), 1);
    chk("t4_hold_ch", int'(out_ch), 0);
    chk("t4_hold_cnt", int'(out_count), 3);
    clr_ovr = 1;
    tick(3);
    chk("t4_setwins", int'(overrun), 1);
    en = 0;
    tick(1);
    chk("t4_cleared", int'(overrun), 0);
    clr_ovr = 0; out_ready = 1;
    tick(1);
    chk("t4_ch1", int'(out_count), 0);
    tick(1);
    chk("t4_ch2", int'(out_count), 3);
    tick(6);
    chk("t4_idle", int'(out_valid), 0);

    // Enable gap stretches the window and drops the gap's spikes.
    do_reset();
    en = 1; win_len = 8'd6; out_ready = 1; spike_in = 8'h02;
    tick(3);
    en = 0;
    tick(5);
    chk("t5_gap_idle", int'(out_valid), 0);
    en = 1;
    tick(2);
    chk("t5_not_yet", int'(out_valid), 0);
    tick(1);
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_ch0", int'(out_count), 0);
    en = 0;
    tick(1);
    chk("t5_ch1", int'(out_count), 6);
    tick(7);

    // Asynchronous reset mid-stream, then a clean restart.
    do_reset();
    en = 1; win_len = 8'd2; spike_in = 8'hFF; out_ready = 1;
    tick(2);
    en = 0;
    chk("t6_cnt0", int'(out_count), 2);
    tick(4);
    chk("t6_ch4", int'(out_ch), 4);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_ch", int'(out_ch), 0);
    win_len = 8'd3; spike_in = 8'h0F;
    tick(1);
    rst = 1'b0; en = 1;
    tick(2);
    chk("t6_no_stale", int'(out_valid), 0);
    tick(1);
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_cnt0", int'(out_count), 3);
    en = 0;
    tick(4);
    chk("t6_ch4_cnt", int'(out_count), 0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receive-side counterpart to the LIF neuron layer. Takes N_CH parallel spike lines, counts spikes per channel over a programmable window of clock cycles, and snapshots the counts into a shadow bank at each window end. The bank is then streamed out one channel per valid/ready beat, so spike trains are converted back into rate values for readout logic or a host interface.

Parameters:
N_CH, 8, number of spike input channels
WIN_W, 8, width of window-length input and window counter
CNT_W, 8, width of each per-channel spike count (saturating)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
en  input  1  counting enable; low freezes window counter and live counts
win_len  input  WIN_W  window length in cycles, sampled at window start
spike_in  input  N_CH  one spike bit per channel, sampled each clk
clr_ovr  input  1  clears sticky overrun flag
out_valid  output  1  readout beat valid
out_ready  input  1  downstream accepts beat
out_ch  output  $clog2(N_CH)  channel index of current beat
out_count  output  CNT_W  spike count for out_ch in last completed window
out_last  output  1  high on beat for channel N_CH-1
overrun  output  1  sticky: a window ended while the readout was busy

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset: all live counts, shadow bank, win_cnt, win_len_q, out_ch, out_count, out_valid, out_last and overrun go to 0. Readout FSM goes to RD_IDLE. Reset mid-stream aborts the stream with no further beats.
- win_len_q latches win_len on the first enabled cycle after reset and on the cycle after each window end. win_len_q==0 means the block is idle: no counting and no window ends.
- Counting, when en=1 and win_len_q!=0: each cycle, live_cnt[i] += spike_in[i], saturating at 2^CNT_W-1. win_cnt increments each cycle.
- Window end is the cycle where en=1 and win_cnt==win_len_q-1. Spikes on that cycle are included in the snapshot. On the next edge, live counts and win_cnt clear to 0, and spikes on the following cycle count toward the new window. Window length is exactly win_len_q cycles.
- en=0 holds win_cnt and live counts unchanged, and no window end can occur. The readout continues independently.
- Snapshot: at window end, if the FSM is in RD_IDLE, or the final beat (out_last & out_ready) is accepted in the same cycle, then bank <= final counts. The FSM enters RD_SEND with out_ch=0 and out_valid=1 on the next cycle (1-cycle latency from window end).
- Overrun: if the FSM is busy at window end and the final beat is not accepted that cycle, that window's counts are dropped, the live counters still clear, and overrun <= 1.
- overrun is cleared by clr_ovr. If clr_ovr and a new overrun occur in the same cycle, set wins.
- Readout FSM states:
  - RD_IDLE: out_valid=0.
  - RD_SEND: out_valid=1, out_count=bank[out_ch], out_last=(out_ch==N_CH-1).
  - On out_valid & out_ready: if not last, out_ch++. If last, go to RD_IDLE and set out_ch=0, unless a snapshot is taken that same cycle; then stay in RD_SEND with out_ch=0 (back-to-back, no bubble).
  - out_ch, out_count and out_last are stable while out_valid=1 and out_ready=0.
- Bank contents are unchanged during a stream; only a snapshot writes the bank.

Decomposition:
- Package snn_pkg: default constants (N_CH, CNT_W, WIN_W) and the readout state enum rd_state_t {RD_IDLE, RD_SEND}.
- Sub-module spike_counter_sat: one channel's saturating counter with inc, clr and en inputs, instantiated N_CH times with a generate loop. The window counter, shadow bank and readout FSM live in the top.

Test Plan:
- win_len=4, spike_in=8'hFF every cycle, out_ready=1 -> out_valid rises 1 cycle after window end; 8 beats, out_ch 0..7, each out_count=4; out_last on ch7; no bubble when the next window's snapshot coincides with the last beat.
- win_len=10, channel 0 spikes on alternate cycles, channel 3 on cycle 9 only -> bank ch0=5, ch3=1, others 0. Spikes on window-end cycle counted; spike on following cycle appears in the next window.
- win_len=255, CNT_W=4, all channels spiking every cycle -> every out_count=15 (saturated), no wrap to 0.
- win_len=3, out_ready=0 held -> first stream holds ch0 stable; second window end sets overrun=1 and the bank stays unchanged. Then clr_ovr pulse -> overrun=0.
- en=0 for 5 cycles mid-window with spikes present -> counts and win_cnt frozen; the window ends 5 cycles later than without the gap; frozen-cycle spikes are not counted.
- Assert rst during RD_SEND at ch4 -> out_valid=0 immediately (async). After release, no stale beats; the first window restarts from 0 using a freshly latched win_len.
